// File: rtl/seg595_frame_decoder.sv
// seg595_frame_decoder: oversampling receiver for the 74HC595 dio/sclk/rclk display link.
module seg595_frame_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dio,
  input  logic        sclk,
  input  logic        rclk,
  output logic [31:0] digits,
  output logic [7:0]  dps,
  output logic [7:0]  digit_valid,
  output logic        frame_valid,
  output logic        scan_done,
  output logic        frame_err,
  output logic        stale
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);
  logic [SYNC_STAGES-1:0] dio_q, sclk_q, rclk_q;
  logic                   sclk_p, rclk_p;
  logic [15:0]            shreg;
  logic [4:0]             cnt;
  logic [7:0]             mask, sel, new_mask;
  logic [TW-1:0]          tcnt;
  logic                   dio_s, sclk_rise, rclk_rise, sel_ok, dec_ok, accept;
  logic [3:0]             dec_val;
  assign dio_s     = dio_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_q[SYNC_STAGES-1] & ~sclk_p;
  assign rclk_rise = rclk_q[SYNC_STAGES-1] & ~rclk_p;
  assign sel       = shreg[7:0];
  assign sel_ok    = (sel != 8'd0) && ((sel & (sel - 8'd1)) == 8'd0);
  assign accept    = rclk_rise && cnt == 5'd16 && sel_ok && dec_ok;
  assign new_mask  = mask | sel;
  assign stale     = tcnt == TMAX;
  always_comb begin
    {dec_ok, dec_val} = 5'b0_0000;
    case (shreg[14:8])
      7'h40: {dec_ok, dec_val} = {1'b1, 4'h0};
      7'h79: {dec_ok, dec_val} = {1'b1, 4'h1};
      7'h24: {dec_ok, dec_val} = {1'b1, 4'h2};
      7'h30: {dec_ok, dec_val} = {1'b1, 4'h3};
      7'h19: {dec_ok, dec_val} = {1'b1, 4'h4};
      7'h12: {dec_ok, dec_val} = {1'b1, 4'h5};
      7'h02: {dec_ok, dec_val} = {1'b1, 4'h6};
      7'h78: {dec_ok, dec_val} = {1'b1, 4'h7};
      7'h00: {dec_ok, dec_val} = {1'b1, 4'h8};
      7'h10: {dec_ok, dec_val} = {1'b1, 4'h9};
      7'h08: {dec_ok, dec_val} = {1'b1, 4'hA};
      7'h03: {dec_ok, dec_val} = {1'b1, 4'hB};
      7'h46: {dec_ok, dec_val} = {1'b1, 4'hC};
      7'h21: {dec_ok, dec_val} = {1'b1, 4'hD};
      7'h06: {dec_ok, dec_val} = {1'b1, 4'hE};
      7'h0E: {dec_ok, dec_val} = {1'b1, 4'hF};
      default: {dec_ok, dec_val} = 5'b0_0000;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dio_q       <= '0;
      sclk_q      <= '0;
      rclk_q      <= '0;
      sclk_p      <= 1'b0;
      rclk_p      <= 1'b0;
      shreg       <= 16'hFFFF;
      cnt         <= 5'd0;
      mask        <= 8'd0;
      tcnt        <= '0;
      digits      <= 32'd0;
      dps         <= 8'd0;
      digit_valid <= 8'd0;
      frame_valid <= 1'b0;
      scan_done   <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      dio_q       <= {dio_q[SYNC_STAGES-2:0], dio};
      sclk_q      <= {sclk_q[SYNC_STAGES-2:0], sclk};
      rclk_q      <= {rclk_q[SYNC_STAGES-2:0], rclk};
      sclk_p      <= sclk_q[SYNC_STAGES-1];
      rclk_p      <= rclk_q[SYNC_STAGES-1];
      frame_valid <= accept;
      frame_err   <= rclk_rise && !accept;
      scan_done   <= accept && new_mask == 8'hFF;
      if (sclk_rise) shreg <= {shreg[14:0], dio_s};
      // a shift coinciding with the latch belongs to the next frame
      cnt  <= rclk_rise ? {4'd0, sclk_rise} : (sclk_rise && cnt != 5'd31) ? cnt + 5'd1 : cnt;
      tcnt <= rclk_rise ? '0 : stale ? tcnt : tcnt + TW'(1);
      if (accept) begin
        mask        <= new_mask == 8'hFF ? 8'd0 : new_mask;
        digit_valid <= digit_valid | sel;
        for (int i = 0; i < 8; i++)
          if (sel[i]) begin
            digits[4*i +: 4] <= dec_val;
            dps[i]           <= ~shreg[15];
          end
      end
    end
  end
endmodule
